reorder_buffer: RTL and testbench

- Circular in-order reorder buffer; its entry indices are the 4-bit producer tags held by the register status table.
- Decode allocates one entry per cycle and writes the returned index into the status table.
- The CDB marks entries complete; the head entry commits in order to the register file.
- At commit, the block drives the status-table clear port, but only when the status table still names this entry as the producer of the destination.

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Entry indices double as the producer tags
// kept by the register status table; index 0 is reserved as "no producer", so
// head and tail walk 1..NUM_ENTRIES and wrap back to 1.
module reorder_buffer #(
    parameter int NUM_ENTRIES = 15,
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_dest,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_index,
    input  logic [IDX_W-1:0]  src1_index,
    output logic              src1_ready,
    output logic [DATA_W-1:0] src1_value,
    input  logic [IDX_W-1:0]  src2_index,
    output logic              src2_ready,
    output logic [DATA_W-1:0] src2_value,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_index,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stat_clear,
    output logic [4:0]        stat_regclear,
    input  logic [IDX_W-1:0]  stat_checkP_index,
    output logic              commit_fire,
    input  logic              flush
);

    localparam int               DEPTH     = 1 << IDX_W;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES);

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [4:0]        dest_q  [DEPTH];
    logic [4:0]        dest_d  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];

    logic              alloc_fire;
    logic              cdb_hit;
    logic [4:0]        head_dest;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? FIRST_IDX : idx + FIRST_IDX;
    endfunction

    // Allocation handshake and head-of-buffer commit decode
    always_comb begin
        alloc_ready   = (count_q != LAST_IDX);
        alloc_index   = tail_q;
        alloc_fire    = alloc_valid && alloc_ready;
        cdb_hit       = cdb_valid && (cdb_index != '0) && busy_q[cdb_index];
        head_dest     = dest_q[head_q];
        commit_fire   = busy_q[head_q] && ready_q[head_q];
        rf_we         = commit_fire && (head_dest != '0);
        rf_waddr      = head_dest;
        rf_wdata      = value_q[head_q];
        stat_regclear = head_dest;
        // Only clear the status entry if a younger producer has not already
        // renamed the register away from this entry.
        stat_clear    = rf_we && (stat_checkP_index == head_q);
    end

    // Operand lookup with same-cycle CDB bypass; tag 0 means "read the RF"
    always_comb begin
        src1_ready = 1'b1;
        src1_value = '0;
        if (src1_index != '0) begin
            if (cdb_valid && (cdb_index == src1_index)) begin
                src1_value = cdb_value;
            end else begin
                src1_ready = ready_q[src1_index];
                src1_value = value_q[src1_index];
            end
        end
        src2_ready = 1'b1;
        src2_value = '0;
        if (src2_index != '0) begin
            if (cdb_valid && (cdb_index == src2_index)) begin
                src2_value = cdb_value;
            end else begin
                src2_ready = ready_q[src2_index];
                src2_value = value_q[src2_index];
            end
        end
    end

    // Next-state: allocate at tail, complete from CDB, retire head; flush wins
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        dest_d  = dest_q;
        value_d = value_q;

        if (alloc_fire) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            dest_d[tail_q]  = alloc_dest;
            tail_d          = next_idx(tail_q);
        end

        if (cdb_hit) begin
            ready_d[cdb_index] = 1'b1;
            value_d[cdb_index] = cdb_value;
        end

        if (commit_fire) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = next_idx(head_q);
        end

        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + IDX_W'(1);
            2'b01:   count_d = count_q - IDX_W'(1);
            default: count_d = count_q;
        endcase

        // Payload fields are left as-is; busy/ready gate every use of them.
        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = FIRST_IDX;
            tail_d  = FIRST_IDX;
            count_d = '0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= FIRST_IDX;
            tail_q  <= FIRST_IDX;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            dest_q  <= dest_d;
            value_q <= value_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected commits into a
// queue, a negedge monitor pops and compares whenever commit_fire is seen.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_ready;
    logic [3:0]  alloc_index;
    logic [3:0]  src1_index;
    logic        src1_ready;
    logic [31:0] src1_value;
    logic [3:0]  src2_index;
    logic        src2_ready;
    logic [31:0] src2_value;
    logic        cdb_valid;
    logic [3:0]  cdb_index;
    logic [31:0] cdb_value;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stat_clear;
    logic [4:0]  stat_regclear;
    logic [3:0]  stat_checkP_index;
    logic        commit_fire;
    logic        flush;

    reorder_buffer #(.NUM_ENTRIES(15), .IDX_W(4), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_dest        (alloc_dest),
        .alloc_ready       (alloc_ready),
        .alloc_index       (alloc_index),
        .src1_index        (src1_index),
        .src1_ready        (src1_ready),
        .src1_value        (src1_value),
        .src2_index        (src2_index),
        .src2_ready        (src2_ready),
        .src2_value        (src2_value),
        .cdb_valid         (cdb_valid),
        .cdb_index         (cdb_index),
        .cdb_value         (cdb_value),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .stat_clear        (stat_clear),
        .stat_regclear     (stat_regclear),
        .stat_checkP_index (stat_checkP_index),
        .commit_fire       (commit_fire),
        .flush             (flush)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        clr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic [4:0] waddr,
                            input logic [31:0] wdata, input logic clr);
        exp_t e;
        e.we = we;
        e.waddr = waddr;
        e.wdata = wdata;
        e.clr = clr;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Commit monitor: every retirement must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && commit_fire) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_commit: got waddr %0d data 0x%0h, expected no commit",
                         rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_rf_we", 32'(rf_we), 32'(mon_e.we));
                chk("commit_rf_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
                chk("commit_regclear", 32'(stat_regclear), 32'(mon_e.waddr));
                chk("commit_rf_wdata", rf_wdata, mon_e.wdata);
                chk("commit_stat_clear", 32'(stat_clear), 32'(mon_e.clr));
            end
        end
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        alloc_dest = '0;
        src1_index = '0;
        src2_index = '0;
        cdb_valid = 1'b0;
        cdb_index = '0;
        cdb_value = '0;
        stat_checkP_index = '0;
        flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_alloc_index", 32'(alloc_index), 32'd1);
        chk("reset_commit_fire", 32'(commit_fire), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_stat_clear", 32'(stat_clear), 32'd0);

        // Basic alloc / complete / commit
        alloc_valid = 1'b1;
        alloc_dest = 5'd5;
        #1;
        chk("t1_alloc_index", 32'(alloc_index), 32'd1);
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_index = 4'd1;
        cdb_value = 32'hAA;
        stat_checkP_index = 4'd1;
        push_exp(1'b1, 5'd5, 32'hAA, 1'b1);
        #1;
        chk("t1_no_cdb_commit_bypass", 32'(commit_fire), 32'd0);
        step();
        cdb_valid = 1'b0;
        @(negedge clk);
        #1;
        stat_checkP_index = 4'd3;
        #1;
        chk("t1_stat_clear_other_tag", 32'(stat_clear), 32'd0);
        stat_checkP_index = 4'd0;
        step();

        // Fill to 15, reject 16th, commit one, wrap
        pulse_rst();
        for (int i = 0; i < 15; i++) begin
            alloc_valid = 1'b1;
            alloc_dest = 5'(16 + i);
            #1;
            chk("t2_fill_alloc_index", 32'(alloc_index), 32'(i + 1));
            step();
        end
        alloc_dest = 5'd9;
        #1;
        chk("t2_full_alloc_ready", 32'(alloc_ready), 32'd0);
        chk("t2_full_alloc_index", 32'(alloc_index), 32'd1);
        step();
        alloc_valid = 1'b0;
        #1;
        chk("t2_ignored_alloc_index", 32'(alloc_index), 32'd1);
        chk("t2_ignored_alloc_ready", 32'(alloc_ready), 32'd0);
        cdb_valid = 1'b1;
        cdb_index = 4'd1;
        cdb_value = 32'h100;
        push_exp(1'b1, 5'd16, 32'h100, 1'b0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk("t2_commit_cycle_fire", 32'(commit_fire), 32'd1);
        chk("t2_full_during_commit", 32'(alloc_ready), 32'd0);
        step();
        chk("t2_after_commit_ready", 32'(alloc_ready), 32'd1);
        chk("t2_after_commit_index", 32'(alloc_index), 32'd1);

        // Out-of-order completion, in-order retirement
        pulse_rst();
        for (int i = 1; i <= 3; i++) begin
            alloc_valid = 1'b1;
            alloc_dest = 5'(i);
            step();
        end
        alloc_valid = 1'b0;
        stat_checkP_index = 4'd2;
        push_exp(1'b1, 5'd1, 32'h11, 1'b0);
        push_exp(1'b1, 5'd2, 32'h22, 1'b1);
        push_exp(1'b1, 5'd3, 32'h33, 1'b0);
        cdb_valid = 1'b1;
        cdb_index = 4'd3;
        cdb_value = 32'h33;
        step();
        cdb_index = 4'd2;
        cdb_value = 32'h22;
        #1;
        chk("t3_head_not_ready", 32'(commit_fire), 32'd0);
        step();
        cdb_index = 4'd1;
        cdb_value = 32'h11;
        step();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_inorder_fire", 32'(commit_fire), 32'd1);
            step();
        end
        #1;
        chk("t3_drained_fire", 32'(commit_fire), 32'd0);
        stat_checkP_index = 4'd0;

        // Operand lookup: bypass, stored value, tag 0
        alloc_valid = 1'b1;
        alloc_dest = 5'd7;
        #1;
        chk("t4_alloc_index", 32'(alloc_index), 32'd4);
        step();
        alloc_valid = 1'b0;
        src1_index = 4'd4;
        src2_index = 4'd0;
        #1;
        chk("t4_src1_not_ready", 32'(src1_ready), 32'd0);
        cdb_valid = 1'b1;
        cdb_index = 4'd4;
        cdb_value = 32'h1234;
        push_exp(1'b1, 5'd7, 32'h1234, 1'b0);
        #1;
        chk("t4_bypass_ready", 32'(src1_ready), 32'd1);
        chk("t4_bypass_value", src1_value, 32'h1234);
        chk("t4_src2_idx0_ready", 32'(src2_ready), 32'd1);
        chk("t4_src2_idx0_value", src2_value, 32'd0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk("t4_stored_ready", 32'(src1_ready), 32'd1);
        chk("t4_stored_value", src1_value, 32'h1234);
        step();
        src1_index = 4'd0;

        // Destination r0: retires without RF write or status clear
        alloc_valid = 1'b1;
        alloc_dest = 5'd0;
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_index = 4'd5;
        cdb_value = 32'h55;
        stat_checkP_index = 4'd5;
        push_exp(1'b0, 5'd0, 32'h55, 1'b0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk("t5_r0_commit_fire", 32'(commit_fire), 32'd1);
        step();
        stat_checkP_index = 4'd0;

        // Flush with concurrent alloc / CDB / commit
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1;
            alloc_dest = 5'(20 + i);
            step();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_index = 4'd6;
        cdb_value = 32'h66;
        push_exp(1'b1, 5'd20, 32'h66, 1'b0);
        step();
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_dest = 5'd3;
        cdb_index = 4'd7;
        cdb_value = 32'h77;
        #1;
        chk("t6_fire_in_flush_cycle", 32'(commit_fire), 32'd1);
        step();
        flush = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid = 1'b0;
        src1_index = 4'd7;
        #1;
        chk("t6_flush_alloc_index", 32'(alloc_index), 32'd1);
        chk("t6_flush_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("t6_flush_commit_fire", 32'(commit_fire), 32'd0);
        chk("t6_flush_src1_ready", 32'(src1_ready), 32'd0);
        src1_index = 4'd0;

        // Asynchronous reset during a commit
        alloc_valid = 1'b1;
        alloc_dest = 5'd9;
        step();
        alloc_dest = 5'd10;
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_index = 4'd1;
        cdb_value = 32'h99;
        step();
        cdb_valid = 1'b0;
        stat_checkP_index = 4'd1;
        #1;
        chk("t7_pre_rst_fire", 32'(commit_fire), 32'd1);
        chk("t7_pre_rst_stat_clear", 32'(stat_clear), 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_commit_fire", 32'(commit_fire), 32'd0);
        chk("t7_rst_rf_we", 32'(rf_we), 32'd0);
        chk("t7_rst_stat_clear", 32'(stat_clear), 32'd0);
        chk("t7_rst_alloc_index", 32'(alloc_index), 32'd1);
        chk("t7_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        stat_checkP_index = 4'd0;
        step();
        rst = 1'b0;
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
